// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo block, its write driver and its read-side master.
package fifo_pkg;

   localparam int unsigned DATA_WIDTH_DEF  = 8;
   localparam int unsigned FIFO_DEPTH_DEF  = 4;
   localparam int unsigned COUNT_WIDTH_DEF = 16;
   localparam int unsigned SKID_OCC_WIDTH  = 2;

   typedef logic [DATA_WIDTH_DEF-1:0] fifo_word_t;
   typedef logic [SKID_OCC_WIDTH-1:0] skid_occ_t;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry circular skid buffer: pushes land at the tail, the head is always presented.
module fifo_skid2
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output skid_occ_t             occ
);

   logic [DATA_WIDTH-1:0] r_mem [2];
   logic                  r_head;
   skid_occ_t             r_occ;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_tail;

   // Pops on an empty buffer and pushes into a full one are ignored.
   assign w_pop  = pop && (r_occ != 2'd0);
   assign w_push = push && ((r_occ != 2'd2) || w_pop);
   assign w_tail = r_head ^ (r_occ != 2'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
         end
         r_head <= 1'b0;
         r_occ  <= 2'd0;
      end else if (clear) begin
         r_head <= 1'b0;
         r_occ  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[w_tail] <= push_data;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign head = r_mem[r_head];
   assign occ  = r_occ;

endmodule

// File: rtl/fifo_reader.sv
// Read-side master for the fifo block: issues rd_en, absorbs the one-cycle read
// latency in a 2-entry skid buffer and presents a valid/ready stream.
module fifo_reader
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   flush,
   input  logic                   fifo_empty,
   input  logic [DATA_WIDTH-1:0]  fifo_data_out,
   output logic                   fifo_rd_en,
   output logic                   m_valid,
   output logic [DATA_WIDTH-1:0]  m_data,
   input  logic                   m_ready,
   output logic [COUNT_WIDTH-1:0] rd_count
);

   logic                   r_inflight;
   logic [COUNT_WIDTH-1:0] r_rd_count;
   skid_occ_t              w_occ;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_rd_en;
   logic [2:0]             w_pending;

   assign m_valid = (w_occ != 2'd0);
   assign w_pop   = m_valid && m_ready;

   // Words owned after this edge: buffered plus in flight, minus the one leaving now.
   assign w_pending = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
   assign w_rd_en   = enable && !flush && !fifo_empty && (w_pending < 3'd2);
   assign w_push    = r_inflight && !flush;

   assign fifo_rd_en = w_rd_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_rd_en;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_count <= '0;
      end else if (flush) begin
         r_rd_count <= '0;
      end else if (w_pop) begin
         r_rd_count <= r_rd_count + COUNT_WIDTH'(1);
      end
   end

   assign rd_count = r_rd_count;

   fifo_skid2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .push      (w_push),
      .push_data (fifo_data_out),
      .pop       (w_pop),
      .head      (m_data),
      .occ       (w_occ)
   );

endmodule
